// File: rtl/led_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-slot dead-time blanking and a frame-synchronous display buffer.
// Optional LEADING_ZERO_BLANK_EN macro suppresses leading zero digits (digit 0 is always shown).
module led_scan_driver #(
  parameter int SLOT_W      = 16,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  localparam logic [SLOT_W-1:0] DEAD_C   = SLOT_W'(DEAD_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_MAX = {SLOT_W{1'b1}};
  localparam logic [SLOT_W-1:0] SLOT_ONE = {{(SLOT_W-1){1'b0}}, 1'b1};

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [19:0]       shadow_q, shadow_d;
  logic [19:0]       display_q, display_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_done_q, frame_done_d;
  logic              suppress;
  logic [3:0]        disp_nib;
  logic [3:0]        disp_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      4'hF:    seg_decode = 7'h0E;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Next-state: shadow capture, slot/digit counters, frame-boundary display update
  always_comb begin
    shadow_d     = load ? {dp, digits} : shadow_q;
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    display_d    = display_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      slot_cnt_d = {SLOT_W{1'b0}};
      idx_d      = 2'd0;
      display_d  = shadow_d;
    end else begin
      slot_cnt_d = slot_cnt_q + SLOT_ONE;
      if (slot_cnt_q == SLOT_MAX) begin
        idx_d = idx_q + 2'd1;
        // Shadow is read through shadow_d so a load on the boundary edge is shown immediately
        if (idx_q == 2'd3) begin
          display_d    = shadow_d;
          frame_done_d = 1'b1;
        end else begin
          display_d    = display_q;
          frame_done_d = 1'b0;
        end
      end else begin
        idx_d = idx_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] digit_nz;

  // A digit is a leading zero when it and every higher digit (value and dp) are zero
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      digit_nz[i] = (|display_d[4*i +: 4]) | display_d[16+i];
    end
    case (idx_d)
      2'd1:    suppress = ~(|digit_nz[3:1]);
      2'd2:    suppress = ~(|digit_nz[3:2]);
      2'd3:    suppress = ~digit_nz[3];
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  assign disp_nib = display_d[{idx_d, 2'b00} +: 4];
  assign disp_dp  = display_d[19:16];

  // Output decode from the next counter values so pins track slot_cnt/idx without lag
  always_comb begin
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (enable && (slot_cnt_d >= DEAD_C) && !suppress) begin
      an_d   = ~(4'b0001 << idx_d);
      seg_d  = seg_decode(disp_nib);
      dp_n_d = ~disp_dp[idx_d];
    end else begin
      an_d   = 4'hF;
      seg_d  = 7'h7F;
      dp_n_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      slot_cnt_q   <= {SLOT_W{1'b0}};
      idx_q        <= 2'd0;
      shadow_q     <= 20'h00000;
      display_q    <= 20'h00000;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver (SLOT_W=3, DEAD_CYCLES=2): decode table, hand sequences, random run vs. frame-position model.
module tb_led_scan_driver;

  localparam int SLOTS = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * SLOTS;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic n_reset, enable, load;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n, frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: position within the frame plus the two value buffers
  int          pos;
  logic [19:0] m_shadow, m_display;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn, e_fd;

  typedef struct {
    logic [3:0] val;
    logic [3:0] dpv;
    logic [6:0] exp_seg;
    logic       exp_dpn;
  } dec_vec_t;
  dec_vec_t vecs [16];

  always #5 clk = ~clk;

  led_scan_driver #(.SLOT_W(3), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable), .load(load),
    .digits(digits), .dp(dp), .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic lit;
    int d;
    lit  = 1'b0;
    e_fd = 1'b0;
    if (!n_reset) begin
      pos = 0; m_shadow = 20'h0; m_display = 20'h0;
    end else begin
      if (load) m_shadow = {dp, digits};
      if (!enable) begin
        pos = 0; m_display = m_shadow;
      end else begin
        pos  = (pos + 1) % FRAME;
        e_fd = (pos == 0);
        if (e_fd) m_display = m_shadow;
        lit = ((pos % SLOTS) >= DEAD);
      end
    end
    d = pos / SLOTS;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && ((m_display[15:0] >> (4*d)) == 16'h0) && ((m_display[19:16] >> d) == 4'h0)) lit = 1'b0;
`endif
    if (lit) begin
      e_an  = ~(4'b0001 << d);
      e_seg = SEG_TAB[(m_display >> (4*d)) & 20'hF];
      e_dpn = ~m_display[16+d];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("an", {28'h0, an}, {28'h0, e_an});
    check("seg", {25'h0, seg}, {25'h0, e_seg});
    check("dp_n", {31'h0, dp_n}, {31'h0, e_dpn});
    check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
  endtask

  initial begin
    logic seen3, seen2, any_fd;
    logic [6:0] seg_d0, seg_d1, seg_d2, seg_d3;
    vecs[0]  = '{4'h0, 4'b0001, 7'h40, 1'b0};
    vecs[1]  = '{4'h1, 4'b0000, 7'h79, 1'b1};
    vecs[2]  = '{4'h2, 4'b0001, 7'h24, 1'b0};
    vecs[3]  = '{4'h3, 4'b0000, 7'h30, 1'b1};
    vecs[4]  = '{4'h4, 4'b1111, 7'h19, 1'b0};
    vecs[5]  = '{4'h5, 4'b0000, 7'h12, 1'b1};
    vecs[6]  = '{4'h6, 4'b0001, 7'h02, 1'b0};
    vecs[7]  = '{4'h7, 4'b1110, 7'h78, 1'b1};
    vecs[8]  = '{4'h8, 4'b0000, 7'h00, 1'b1};
    vecs[9]  = '{4'h9, 4'b0001, 7'h10, 1'b0};
    vecs[10] = '{4'hA, 4'b0000, 7'h08, 1'b1};
    vecs[11] = '{4'hB, 4'b0011, 7'h03, 1'b0};
    vecs[12] = '{4'hC, 4'b0000, 7'h46, 1'b1};
    vecs[13] = '{4'hD, 4'b0001, 7'h21, 1'b0};
    vecs[14] = '{4'hE, 4'b0000, 7'h06, 1'b1};
    vecs[15] = '{4'hF, 4'b0001, 7'h0E, 1'b0};

    // Reset wins over load and enable
    n_reset = 1'b0; enable = 1'b1; load = 1'b1; digits = 16'hFFFF; dp = 4'hF;
    pos = 0; m_shadow = 20'h0; m_display = 20'h0;
    repeat (3) step();
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_dp_n", {31'h0, dp_n}, 32'h1);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    n_reset = 1'b1; load = 1'b0;
    step();
    check("post_rst_blank", {28'h0, an}, 32'hF);
    step();
    check("post_rst_an", {28'h0, an}, 32'hE);
    check("post_rst_seg", {25'h0, seg}, 32'h40);

    // Decode table on digit 0
    for (int i = 0; i < 16; i++) begin
      enable = 1'b0; load = 1'b1; digits = {4{vecs[i].val}}; dp = vecs[i].dpv;
      step();
      load = 1'b0; enable = 1'b1;
      step();
      step();
      check("dec_an", {28'h0, an}, 32'hE);
      check($sformatf("dec_seg_%0h", vecs[i].val), {25'h0, seg}, {25'h0, vecs[i].exp_seg});
      check("dec_dp_n", {31'h0, dp_n}, {31'h0, vecs[i].exp_dpn});
    end

    // 1234 scan, mid-frame load of ABCD, boundary-edge load of 5555
    enable = 1'b0; load = 1'b1; digits = 16'h1234; dp = 4'b0000;
    step();
    enable = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      load = (c == 10) || (c == 64);
      digits = (c == 64) ? 16'h5555 : 16'hABCD;
      dp = (c == 64) ? 4'b0000 : 4'b0001;
      step();
      case (c)
        2:  begin check("s_d0_an", {28'h0, an}, 32'hE); check("s_d0_seg", {25'h0, seg}, 32'h19); end
        10: begin check("s_d1_an", {28'h0, an}, 32'hD); check("s_d1_seg", {25'h0, seg}, 32'h30); end
        18: begin check("s_d2_an", {28'h0, an}, 32'hB); check("s_d2_seg", {25'h0, seg}, 32'h24); end
        26: begin check("s_d3_an", {28'h0, an}, 32'h7); check("s_d3_seg", {25'h0, seg}, 32'h79); end
        32: check("s_fd1", {31'h0, frame_done}, 32'h1);
        34: begin check("n_d0_seg", {25'h0, seg}, 32'h21); check("n_d0_dp", {31'h0, dp_n}, 32'h0); end
        42: check("n_d1_seg", {25'h0, seg}, 32'h46);
        50: check("n_d2_seg", {25'h0, seg}, 32'h03);
        58: check("n_d3_seg", {25'h0, seg}, 32'h08);
        64: check("s_fd2", {31'h0, frame_done}, 32'h1);
        66: check("bnd_d0_seg", {25'h0, seg}, 32'h12);
        default: ;
      endcase
    end
    load = 1'b0;

    // Drop enable in digit 2 lit phase, restart without frame_done
    for (int k = 0; k < FRAME && pos != 20; k++) step();
    check("at_d2", {28'h0, an}, 32'hB);
    enable = 1'b0;
    step();
    check("dis_an", {28'h0, an}, 32'hF);
    check("dis_seg", {25'h0, seg}, 32'h7F);
    enable = 1'b1;
    step();
    check("re_blank", {28'h0, an}, 32'hF);
    step();
    check("re_d0", {28'h0, an}, 32'hE);
    any_fd = 1'b0;
    for (int k = 0; k < 29; k++) begin
      step();
      any_fd = any_fd | frame_done;
    end
    check("re_no_fd", {31'h0, any_fd}, 32'h0);

    // Leading zeros 0050
    enable = 1'b0; load = 1'b1; digits = 16'h0050; dp = 4'b0000;
    step();
    load = 1'b0; enable = 1'b1;
    seen3 = 1'b0; seen2 = 1'b0;
    seg_d0 = 7'h7F; seg_d1 = 7'h7F; seg_d2 = 7'h7F; seg_d3 = 7'h7F;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (!an[3]) begin seen3 = 1'b1; seg_d3 = seg; end
      if (!an[2]) begin seen2 = 1'b1; seg_d2 = seg; end
      if (!an[1]) seg_d1 = seg;
      if (!an[0]) seg_d0 = seg;
    end
    check("lz_d1_seg", {25'h0, seg_d1}, 32'h12);
    check("lz_d0_seg", {25'h0, seg_d0}, 32'h40);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_an3_lit", {31'h0, seen3}, 32'h0);
    check("lz_an2_lit", {31'h0, seen2}, 32'h0);
`else
    check("lz_an3_lit", {31'h0, seen3}, 32'h1);
    check("lz_an2_lit", {31'h0, seen2}, 32'h1);
    check("lz_d3_seg", {25'h0, seg_d3}, 32'h40);
    check("lz_d2_seg", {25'h0, seg_d2}, 32'h40);
`endif

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      n_reset = ($urandom % 150) != 0;
      enable  = ($urandom % 25) != 0;
      load    = ($urandom % 10) == 0;
      digits  = 16'($urandom);
      if ($urandom % 2 == 1) digits = digits & (16'hFFFF >> (4 * ($urandom % 4)));
      dp      = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
Output-side companion to the team's input conditioning logic: drives a four-digit, common-anode, seven-segment display from a 16-bit hex value.
- Time-multiplexes the four digits, one slot per digit.
- Inserts a dead-time blanking interval at the start of every slot to suppress ghosting.
- Double-buffers the value so a new value is never displayed mid-frame.
- Sits between core logic (value/load) and the board pins (an/seg/dp_n).

Parameters:
SLOT_W, 16, slot length is 2^SLOT_W clocks per digit.
DEAD_CYCLES, 64, blank clocks at the start of each slot; legal range 0 .. 2^SLOT_W-1; out of range is undefined.

Ports:
clk  input  1  system clock
n_reset  input  1  reset, synchronous, active-low; clock clk
enable  input  1  scan enable; low blanks the display and restarts the scan
load  input  1  one-clock strobe; captures digits/dp into the shadow register
digits  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
dp  input  4  decimal point per digit, active-high, same indexing as digits
an  output  4  anode enables, active-low; an[k] = digit k
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  output  1  decimal point segment, active-low
frame_done  output  1  one-clock pulse at the start of each new frame

Behaviour:
- Reset (n_reset=0 at a clk edge):
  - Outputs: an=4'b1111, seg=7'h7F, dp_n=1, frame_done=0.
  - Internal state: slot_cnt=0, idx=0, shadow and display registers = 0.
  - Reset wins over load and enable.
- All outputs are registered and change together with slot_cnt/idx. Output values always correspond to the current slot_cnt/idx. There is no extra pipeline latency.
- Shadow register: on an edge with load=1, shadow <= {dp, digits}. Load is accepted regardless of enable.
- Scan while enable=1: slot_cnt increments every clock (SLOT_W bits, wraps).
  - slot_cnt < DEAD_CYCLES: blank phase; an=1111, seg=7F, dp_n=1.
  - Otherwise: active phase; an has only bit idx low, seg = decode(display nibble idx), dp_n = ~display dp[idx].
  - On slot_cnt wrap, idx increments 0→1→2→3→0.
  - Frame boundary is the wrap from idx=3 to idx=0. On that edge:
    - display <= shadow. If load=1 on the same edge, the newly loaded value is forwarded and shown in the new frame.
    - frame_done=1 for exactly that one cycle (slot_cnt=0, idx=0).
- enable=0 at an edge:
  - Next cycle: an=1111, seg=7F, dp_n=1, slot_cnt=0, idx=0, frame_done=0.
  - display <= shadow every cycle while disabled, including a same-edge load.
  - When enable returns to 1, scanning starts at digit 0 in the blank phase. frame_done does not pulse for this restart.
- Frame period: 4·2^SLOT_W clocks. Per slot: DEAD_CYCLES blank clocks followed by 2^SLOT_W−DEAD_CYCLES lit clocks. DEAD_CYCLES=0 means no blanking.
- Decode table, hex value → seg:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Reset asserted mid-frame: the next edge forces the reset state and discards both the pending shadow and display contents.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Digit k (k=3,2,1) is suppressed iff display nibbles k..3 are all zero AND dp[k..3] are all zero.
  - A suppressed digit keeps an=1111, seg=7F and dp_n=1 for its entire slot.
  - Slot timing and frame_done are unchanged.
  - Digit 0 is never suppressed.
- Undefined: all four digits are always lit in their active phase.

Test Plan:
1. Reset: hold n_reset=0 for 3 clks with enable=1, load=1 → an=1111, seg=7F, dp_n=1, frame_done=0. After release, digit 0 shows "0" (seg=40) once slot_cnt reaches DEAD_CYCLES.
2. SLOT_W=3, DEAD_CYCLES=2, enable=0; load digits=16'h1234, dp=4'b0000; then enable=1 →
   - Per slot: 2 blank clocks, then 6 lit clocks.
   - Lit values: an=1110/seg=19, an=1101/seg=30, an=1011/seg=24, an=0111/seg=79.
   - frame_done pulses 32 clocks after enable rises.
3. Same setup; load 16'hABCD, dp=4'b0001 at clock 10 → rest of the frame still shows 1,2,3,4. Next frame shows seg 21 (with dp_n=0), 46, 03, 08 on digits 0–3.
4. Load 16'h5555 on the exact frame-boundary edge → the new frame's digit 0 shows seg=12. No frame shows mixed old/new digits.
5. Drop enable in the lit phase of digit 2 → next clock an=1111, seg=7F. When enable is reasserted, two blank clocks, then digit 0 lit. No frame_done pulse for the restart.
6. Load 16'h0050, dp=0 →
   - With LEADING_ZERO_BLANK_EN: an[3] and an[2] never go low; digit 1 shows seg=12; digit 0 shows seg=40.
   - Without the macro: all four anodes are lit in turn; digits 3 and 2 show seg=40.
